cfg_shadow_regs: RTL

Second-generation configuration register bank for the systolic array controller. Host writes land in a shadow bank with byte strobes and address checking. A commit handshake copies the whole shadow bank atomically into the active bank. The copy happens only when the array reports idle, so the array never sees a half-updated configuration mid-tile. Host readback is registered and comes from the shadow bank.

---
 rtl/cfg_shadow_regs_pkg.sv | 27 ++
 rtl/cfg_shadow_regs_if.sv | 65 ++++++
 rtl/cfg_shadow_regs_fsm.sv | 62 ++++++
 rtl/cfg_shadow_regs.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/cfg_shadow_regs_pkg.sv
// cfg_regs_pkg
// Shared definitions for the configuration shadow register bank:
// commit FSM state encoding and the byte-lane merge helper used when
// applying strobed host writes to a shadow register.
package cfg_regs_pkg;

    // Commit FSM state encoding.
    localparam logic [1:0] IDLE_ENC    = 2'd0;
    localparam logic [1:0] PENDING_ENC = 2'd1;
    localparam logic [1:0] COPY_ENC    = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = IDLE_ENC,
        PENDING = PENDING_ENC,
        COPY    = COPY_ENC
    } commit_state_t;

    // Byte-lane merge: the new byte replaces the old one only when its strobe is set.
    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       strb
    );
        return strb ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/cfg_shadow_regs_if.sv
// cfg_shadow_regs_if
// Host-side bus of the configuration register bank: the strobed write
// channel, the registered read channel and the commit handshake.
// The host drives through the master modport; the register bank sits
// on the slave modport.
interface cfg_shadow_regs_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
);

    // Write channel.
    logic                      wr_valid;
    logic                      wr_ready;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic [DATA_WIDTH/8-1:0]   wr_strb;
    logic                      wr_err;

    // Read channel.
    logic                      rd_valid;
    logic [ADDR_WIDTH-1:0]     rd_addr;
    logic                      rd_data_valid;
    logic [DATA_WIDTH-1:0]     rd_data;
    logic                      rd_err;

    // Commit handshake.
    logic                      commit_req;
    logic                      commit_pending;
    logic                      commit_done;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        output wr_strb,
        input  wr_ready,
        input  wr_err,
        output rd_valid,
        output rd_addr,
        input  rd_data_valid,
        input  rd_data,
        input  rd_err,
        output commit_req,
        input  commit_pending,
        input  commit_done
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        input  wr_strb,
        output wr_ready,
        output wr_err,
        input  rd_valid,
        input  rd_addr,
        output rd_data_valid,
        output rd_data,
        output rd_err,
        input  commit_req,
        output commit_pending,
        output commit_done
    );

endinterface

// File: rtl/cfg_shadow_regs_fsm.sv
// cfg_commit_fsm
// Sequences a commit request: waits in PENDING until the array is idle,
// spends exactly one COPY cycle in which the datapath copies shadow into
// active, then pulses commit_done on the following cycle. Requests that
// arrive while a commit is already in flight are dropped, not queued.
module cfg_commit_fsm
    import cfg_regs_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic commit_req,
    input  logic array_idle,
    output logic commit_pending,
    output logic commit_done,
    output logic copy_en,
    output logic wr_ready
);

    commit_state_t state_q;
    commit_state_t state_d;

    // State register plus the registered commit_done pulse that follows the COPY cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            commit_done <= 1'b0;
        end else begin
            state_q     <= state_d;
            commit_done <= (state_q == COPY);
        end
    end

    // Next-state and Moore outputs; COPY always lasts exactly one cycle and blocks writes.
    always_comb begin
        state_d        = state_q;
        commit_pending = 1'b0;
        copy_en        = 1'b0;
        wr_ready       = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (commit_req) begin
                    state_d = PENDING;
                end
            end
            PENDING: begin
                commit_pending = 1'b1;
                if (array_idle) begin
                    state_d = COPY;
                end
            end
            COPY: begin
                copy_en  = 1'b1;
                wr_ready = 1'b0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/cfg_shadow_regs.sv
// cfg_shadow_regs
// Configuration register bank for the systolic array controller.
// Host writes go to a shadow bank (byte strobes, range checked); a commit
// copies the whole shadow bank into the active bank in a single cycle,
// and only while the array is idle, so the array never observes a
// partially updated configuration. Readback is registered and always
// reflects the shadow bank.
module cfg_shadow_regs
    import cfg_regs_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 4,
    parameter int                    DATA_WIDTH    = 16,
    parameter int                    NUM_REGISTERS = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    cfg_shadow_regs_if.slave                      host,
    input  logic                                  array_idle,
    output logic [NUM_REGISTERS-1:0]              shadow_dirty,
    output logic [NUM_REGISTERS*DATA_WIDTH-1:0]   active_flat
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int IDX_W     = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1;
    // Register count widened by one bit so it can be compared against any address.
    localparam logic [ADDR_WIDTH:0] NUM_REGS_EXT = (ADDR_WIDTH + 1)'(NUM_REGISTERS);

    logic [DATA_WIDTH-1:0] shadow_q [NUM_REGISTERS];
    logic [DATA_WIDTH-1:0] active_q [NUM_REGISTERS];
    logic [DATA_WIDTH-1:0] wr_merged;

    logic                  wr_fire;
    logic                  wr_in_range;
    logic [IDX_W-1:0]      wr_idx;
    logic                  rd_in_range;
    logic [IDX_W-1:0]      rd_idx;
    logic                  copy_en;

    logic                  wr_err_q;
    logic                  rd_data_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_err_q;

    cfg_commit_fsm u_commit_fsm (
        .clk            (clk),
        .rst_n          (rst_n),
        .commit_req     (host.commit_req),
        .array_idle     (array_idle),
        .commit_pending (host.commit_pending),
        .commit_done    (host.commit_done),
        .copy_en        (copy_en),
        .wr_ready       (host.wr_ready)
    );

    assign wr_fire     = host.wr_valid && host.wr_ready;
    assign wr_in_range = ({1'b0, host.wr_addr} < NUM_REGS_EXT);
    assign wr_idx      = host.wr_addr[IDX_W-1:0];
    assign rd_in_range = ({1'b0, host.rd_addr} < NUM_REGS_EXT);
    assign rd_idx      = host.rd_addr[IDX_W-1:0];

    // Merge the strobed bytes of the incoming write over the addressed shadow register.
    always_comb begin
        wr_merged = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            wr_merged[8*b +: 8] = byte_merge(shadow_q[wr_idx][8*b +: 8],
                                             host.wr_data[8*b +: 8],
                                             host.wr_strb[b]);
        end
    end

    // Shadow bank: updated by accepted in-range host writes only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                shadow_q[i] <= RESET_VALUE;
            end
        end else if (wr_fire && wr_in_range) begin
            shadow_q[wr_idx] <= wr_merged;
        end
    end

    // Dirty flags: any accepted in-range write marks its register, even with no strobes; a commit clears all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_dirty <= '0;
        end else if (copy_en) begin
            shadow_dirty <= '0;
        end else if (wr_fire && wr_in_range) begin
            shadow_dirty[wr_idx] <= 1'b1;
        end
    end

    // Active bank: whole-bank copy at the closing edge of the COPY cycle, otherwise frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                active_q[i] <= RESET_VALUE;
            end
        end else if (copy_en) begin
            for (int i = 0; i < NUM_REGISTERS; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    // Flag an accepted write that addressed a register that does not exist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= wr_fire && !wr_in_range;
        end
    end

    // Registered readback sampled before any same-cycle write lands; data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_valid_q <= 1'b0;
            rd_data_q       <= '0;
            rd_err_q        <= 1'b0;
        end else begin
            rd_data_valid_q <= host.rd_valid;
            if (host.rd_valid) begin
                if (rd_in_range) begin
                    rd_data_q <= shadow_q[rd_idx];
                    rd_err_q  <= 1'b0;
                end else begin
                    rd_data_q <= '0;
                    rd_err_q  <= 1'b1;
                end
            end
        end
    end

    assign host.wr_err        = wr_err_q;
    assign host.rd_data_valid = rd_data_valid_q;
    assign host.rd_data       = rd_data_q;
    assign host.rd_err        = rd_err_q;

    for (genvar g = 0; g < NUM_REGISTERS; g++) begin : g_active_flat
        assign active_flat[g*DATA_WIDTH +: DATA_WIDTH] = active_q[g];
    end

endmodule
